mem_ctrl: RTL and testbench

- CPU-side initiator of the 8-bit system memory bus: the driver of mem_a/mem_wr/mem_dout, consuming mem_din.
- Serialises word-level requests from instruction fetch (IF) and load/store (LS) into byte-wide RAM/IO accesses.
- Reassembles read data and pauses on rdy_in and on io_buffer_full.
- Instantiated inside cpu; all bus ports connect directly to the cpu top-level memory ports.

---
 rtl/mem_ctrl.sv | 96 +++++++++
 tb/tb_mem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory bus initiator serving IF word fetches and LS loads/stores
// Ports: clk_in, rst_in (async, active-low); rdy_in bus grant (0 freezes the controller);
//   mem_a/mem_wr/mem_dout drive the byte bus, mem_din returns read data one cycle after its address;
//   io_buffer_full throttles IO-region writes; if_req/if_addr/if_done/if_data fetch handshake;
//   flush aborts an in-flight fetch; ls_req/ls_we/ls_size/ls_addr/ls_wdata/ls_done/ls_rdata load/store handshake.
module mem_ctrl #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        flush,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t      state, state_nx;
    logic [31:0] base, wdata, asm_q, addr;
    logic [2:0]  n, i, j;
    logic        own_if, vld, cd, io, iss, wr_go, cap, abort, start;

    // i is the issue pointer, j the capture pointer; vld marks that last cycle issued a byte
    // while the bus was granted, so mem_din this cycle is trustworthy.
    // cd blocks the IO write right after another one until the registered full flag catches up.
    always_comb begin
        addr     = base + {29'd0, i};
        io       = addr[17:16] == IO_ADDR_HI;
        iss      = state == READ && rdy_in && i < n;
        wr_go    = state == WRITE && rdy_in && !(io && (io_buffer_full || cd));
        cap      = state == READ && rdy_in && vld;
        abort    = own_if && flush && (state == READ || state == DONE);
        start    = state == IDLE && rdy_in && (ls_req || (if_req && !flush));
        state_nx = state;
        if (abort) state_nx = IDLE;
        else if (start) state_nx = (ls_req && ls_we) ? WRITE : READ;
        else if (cap && j == n - 3'd1) state_nx = DONE;
        else if (wr_go && i == n - 3'd1) state_nx = DONE;
        else if (state == DONE && rdy_in) state_nx = IDLE;
        mem_wr   = wr_go;
        mem_a    = (iss || wr_go) ? addr : 32'd0;
        mem_dout = wr_go ? wdata[{i[1:0], 3'b000} +: 8] : 8'd0;
        if_done  = state == DONE && own_if && rdy_in && !flush;
        ls_done  = state == DONE && !own_if && rdy_in;
        if_data  = if_done ? asm_q : 32'd0;
        ls_rdata = ls_done ? asm_q : 32'd0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state  <= IDLE;
            base   <= 32'd0;
            wdata  <= 32'd0;
            asm_q  <= 32'd0;
            n      <= 3'd0;
            i      <= 3'd0;
            j      <= 3'd0;
            own_if <= 1'b0;
            vld    <= 1'b0;
            cd     <= 1'b0;
        end else begin
            state <= state_nx;
            vld   <= iss;
            cd    <= wr_go && io;
            if (start) begin
                base   <= ls_req ? ls_addr : if_addr;
                wdata  <= ls_wdata;
                n      <= !ls_req ? 3'd4 : ls_size == 2'd0 ? 3'd1 : ls_size == 2'd1 ? 3'd2 : 3'd4;
                own_if <= !ls_req;
                i      <= 3'd0;
                j      <= 3'd0;
                asm_q  <= 32'd0;
            end
            if (iss || wr_go) i <= i + 3'd1;
            // a stall loses the byte in flight, so reissue from the first uncaptured byte
            if (state == READ && !rdy_in) i <= j;
            if (cap) begin
                asm_q[{j[1:0], 3'b000} +: 8] <= mem_din;
                j <= j + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a byte RAM model and a done scoreboard
module tb_mem_ctrl;
    logic        clk = 0, rst_n = 0, rdy_in = 1, io_buffer_full = 0;
    logic        if_req = 0, flush = 0, ls_req = 0, ls_we = 0;
    logic [1:0]  ls_size = 0;
    logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a, if_data, ls_rdata;
    logic        mem_wr, if_done, ls_done;

    mem_ctrl dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy_in), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data), .flush(flush),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (!rst_n) begin
            ram[16'h0100] <= 8'h13;
            ram[16'h0101] <= 8'h05;
            ram[16'h0102] <= 8'h50;
            ram[16'h0103] <= 8'h00;
            ram[16'h0040] <= 8'h9C;
            ram[16'h2002] <= 8'h77;
        end else if (mem_wr && mem_a[17:16] != 2'b11) begin
            ram[mem_a[15:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[15:0]];
    end

    typedef struct { logic is_if; logic chk; logic [31:0] d; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; int c; } log_t;
    typedef struct { logic we; logic [1:0] sz; logic [31:0] a; logic [31:0] wd; logic [31:0] exp_d; } vec_t;

    exp_t exp_q[$];
    log_t rd_log[$], wr_log[$];
    vec_t vt[10];
    int   n_cmp = 0, n_fail = 0;
    int   dc, dc_ls, dc_if;
    bit   got;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endfunction

    // Logs bus traffic and retires scoreboard entries on every done pulse.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_wr) begin
                    wr_log.push_back('{mem_a, mem_dout, cyc});
                    check("wr_while_full", 32'(io_buffer_full), 32'd0);
                end else if (mem_a != 32'd0 && rdy_in) begin
                    rd_log.push_back('{mem_a, 8'd0, cyc});
                end
                if (if_done || ls_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", {30'd0, if_done, ls_done}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_owner", {30'd0, if_done, ls_done}, e.is_if ? 32'd2 : 32'd1);
                        if (e.chk) check(e.is_if ? "if_data" : "ls_rdata", e.is_if ? if_data : ls_rdata, e.d);
                    end
                end
            end
        end
    endtask

    task automatic do_req(input bit is_if, input bit we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, output int dcyc);
        bit seen;
        @(posedge clk);
        #1;
        if (is_if) begin
            if_req  = 1;
            if_addr = a;
        end else begin
            ls_req   = 1;
            ls_we    = we;
            ls_size  = sz;
            ls_addr  = a;
            ls_wdata = wd;
        end
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = is_if ? if_done : ls_done;
        end
        check(is_if ? "if_done_seen" : "ls_done_seen", 32'(seen), 32'd1);
        dcyc = cyc;
        @(posedge clk);
        #1;
        if (is_if) if_req = 0;
        else ls_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 2'd2, 32'h0000_3000, 32'h1122_3344, 32'h0};
        vt[1] = '{1'b0, 2'd2, 32'h0000_3000, 32'h0,         32'h1122_3344};
        vt[2] = '{1'b0, 2'd1, 32'h0000_3002, 32'h0,         32'h0000_1122};
        vt[3] = '{1'b0, 2'd0, 32'h0000_3001, 32'h0,         32'h0000_0033};
        vt[4] = '{1'b1, 2'd0, 32'h0000_3003, 32'hFFFF_FFEE, 32'h0};
        vt[5] = '{1'b0, 2'd2, 32'h0000_3000, 32'h0,         32'hEE22_3344};
        vt[6] = '{1'b0, 2'd3, 32'h0000_3000, 32'h0,         32'hEE22_3344};
        vt[7] = '{1'b1, 2'd1, 32'h0001_FFFF, 32'h1234_BEEF, 32'h0};
        vt[8] = '{1'b0, 2'd1, 32'h0001_FFFF, 32'h0,         32'h0000_BEEF};
        vt[9] = '{1'b0, 2'd0, 32'h0002_0000, 32'h0,         32'h0000_00BE};
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        if_req = 1;
        ls_req = 1;
        @(negedge clk);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_if_done", 32'(if_done), 32'd0);
        check("rst_ls_done", 32'(ls_done), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        #1;
        if_req = 0;
        ls_req = 0;
        @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);

        // word fetch
        rd_log.delete();
        exp_q.push_back('{1'b1, 1'b1, 32'h0050_0513});
        do_req(1, 0, 2'd2, 32'h100, 32'd0, dc);
        check("fetch_nreads", rd_log.size(), 32'd4);
        if (rd_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("fetch_addr", rd_log[k].a, 32'h100 + k);
                check("fetch_cycle", rd_log[k].c - rd_log[0].c, k);
            end
            check("fetch_latency", dc - rd_log[0].c, 32'd5);
        end

        // half store
        wr_log.delete();
        exp_q.push_back('{1'b0, 1'b0, 32'd0});
        do_req(0, 1, 2'd1, 32'h2000, 32'hAABB_CCDD, dc);
        check("sth_nwrites", wr_log.size(), 32'd2);
        if (wr_log.size() == 2) begin
            check("sth_a0", wr_log[0].a, 32'h2000);
            check("sth_d0", 32'(wr_log[0].d), 32'hDD);
            check("sth_a1", wr_log[1].a, 32'h2001);
            check("sth_d1", 32'(wr_log[1].d), 32'hCC);
            check("sth_back2back", wr_log[1].c - wr_log[0].c, 32'd1);
            check("sth_done_cycle", dc - wr_log[1].c, 32'd1);
        end
        check("sth_ram_2002", 32'(ram[16'h2002]), 32'h77);

        // simultaneous requests: load first, fetch after one idle cycle
        rd_log.delete();
        exp_q.push_back('{1'b0, 1'b1, 32'h0000_009C});
        exp_q.push_back('{1'b1, 1'b1, 32'h0050_0513});
        fork
            do_req(0, 0, 2'd0, 32'h40, 32'd0, dc_ls);
            do_req(1, 0, 2'd2, 32'h100, 32'd0, dc_if);
        join
        check("arb_nreads", rd_log.size(), 32'd5);
        if (rd_log.size() >= 2) begin
            check("arb_first_addr", rd_log[0].a, 32'h40);
            check("arb_fetch_addr", rd_log[1].a, 32'h100);
            check("arb_fetch_start", rd_log[1].c - dc_ls, 32'd2);
        end

        // IO word store throttled by a full UART buffer
        wr_log.delete();
        io_buffer_full = 1;
        exp_q.push_back('{1'b0, 1'b0, 32'd0});
        fork
            do_req(0, 1, 2'd2, 32'h3_0000, 32'h0A0A_0A0A, dc);
            begin
                repeat (10) @(posedge clk);
                #1 io_buffer_full = 0;
            end
        join
        check("io_nwrites", wr_log.size(), 32'd4);
        if (wr_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("io_addr", wr_log[k].a, 32'h3_0000 + k);
                check("io_data", 32'(wr_log[k].d), 32'h0A);
                if (k > 0) check("io_gap_ge2", 32'(wr_log[k].c - wr_log[k-1].c >= 2), 32'd1);
            end
        end

        // table of loads/stores
        for (int v = 0; v < 10; v++) begin
            exp_q.push_back('{1'b0, !vt[v].we, vt[v].exp_d});
            do_req(0, vt[v].we, vt[v].sz, vt[v].a, vt[v].wd, dc);
        end

        // fetch with a 3-cycle bus freeze after byte 1 is issued
        rd_log.delete();
        exp_q.push_back('{1'b1, 1'b1, 32'h0050_0513});
        fork
            do_req(1, 0, 2'd2, 32'h100, 32'd0, dc);
            begin
                got = 0;
                for (int k = 0; k < 50 && !got; k++) begin
                    @(negedge clk);
                    got = mem_a == 32'h101;
                end
                check("stall_sync", 32'(got), 32'd1);
                @(posedge clk);
                #1 rdy_in = 0;
                repeat (3) @(posedge clk);
                #1 rdy_in = 1;
            end
        join
        check("stall_nreads", rd_log.size(), 32'd5);
        if (rd_log.size() == 5) begin
            check("stall_reissue", rd_log[2].a, 32'h101);
            check("stall_latency", dc - rd_log[0].c, 32'd9);
        end

        // flush during fetch byte 2
        @(posedge clk);
        #1;
        if_req  = 1;
        if_addr = 32'h100;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = mem_a == 32'h102;
        end
        check("flush_sync", 32'(got), 32'd1);
        #1 flush = 1;
        @(posedge clk);
        #1;
        flush  = 0;
        if_req = 0;
        @(negedge clk);
        check("flush_mem_a", mem_a, 32'd0);
        repeat (5) @(negedge clk);

        // reset in the middle of a store
        @(posedge clk);
        #1;
        ls_req   = 1;
        ls_we    = 1;
        ls_size  = 2'd2;
        ls_addr  = 32'h2100;
        ls_wdata = 32'h1234_5678;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = mem_wr;
        end
        check("rstmid_sync", 32'(got), 32'd1);
        #2 rst_n = 0;
        #1;
        check("rstmid_mem_a", mem_a, 32'd0);
        check("rstmid_mem_wr", 32'(mem_wr), 32'd0);
        check("rstmid_mem_dout", 32'(mem_dout), 32'd0);
        check("rstmid_ls_done", 32'(ls_done), 32'd0);
        ls_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (6) @(negedge clk);

        check("pending_dones", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
